apb_regbank_slave: RTL and testbench
====================================

# apb_regbank_slave

APB3 register-bank slave that consumes the 32-bit APB side of the AXI-to-APB bridge (12-bit address, 32-bit data). It holds a bank of 32-bit read/write control registers plus two read-only registers: an identification register and an access counter. It inserts a programmable number of wait states and raises `pslverr` on illegal accesses. Register contents are exported as a flat vector for peripheral logic.

## Interface
- `NUM_REGS`, 8: number of RW registers; legal range 1..1022. They sit at offsets `0x000 .. 4*(NUM_REGS-1)`.
- `WAIT_CYCLES`, 0: wait states inserted in every ACCESS phase; range 0..15.
- `ID_VALUE`, 32'hA5B0_0001: constant returned at offset `0xFFC`.
- `clk_i` input 1: single clock; all state updates on its rising edge.
- `rst_i` input 1: reset. Synchronous and active-high.
- `paddr_i` input 12: APB address.
- `psel_i` input 1: APB select.
- `penable_i` input 1: APB enable.
- `pwrite_i` input 1: 1 = write, 0 = read.
- `pwdata_i` input 32: write data.
- `prdata_o` output 32: read data. Valid only when `pready_o`; 0 otherwise.
- `pready_o` output 1: transfer complete.
- `pslverr_o` output 1: error response. Valid only when `pready_o`; 0 otherwise.
- `regs_o` output 32*NUM_REGS: register *i* is at bits `[32*i+31:32*i]`.

## Operation
- **Address decode.** Let `idx = paddr_i[11:2]`.
  - RW hit: `paddr_i[1:0]==0` and `idx<NUM_REGS`.
  - CNT hit: `paddr_i==0xFF8`.
  - ID hit: `paddr_i==0xFFC`.
  - Everything else is an error access. This includes any misaligned address and any hole in the address map.
- **Write, RW hit.** On the completion cycle, `pwdata_i` is stored in `regs[idx]`. `pslverr_o=0`.
- **Write to CNT or ID, or any error access.** No register changes. `pslverr_o=1`.
- **Read.**
  - RW hit returns `regs[idx]`; CNT hit returns the counter; ID hit returns `ID_VALUE`. `pslverr_o=0`.
  - Error read returns `prdata_o=0` with `pslverr_o=1`.
- **Access counter.** 32-bit. Increments by 1 on every completion cycle, whether the access succeeded or errored, read or write. It wraps from `0xFFFF_FFFF` to 0.
  - A read of CNT returns the value *before* that transfer's own increment.
- **FSM (states IDLE, ACCESS).**
  - IDLE -> ACCESS when `psel_i & penable_i`.
  - ACCESS -> IDLE on the completion cycle, or whenever `psel_i` or `penable_i` is low.
  - Wait counter `wcnt` (4 bits):
    - cleared in IDLE;
    - increments each ACCESS cycle without completion;
    - cleared on completion.
- **Completion cycle.** `pready_o = psel_i & penable_i & (wcnt==WAIT_CYCLES)`. This is combinational from the inputs and the registered `wcnt`.
  - With `WAIT_CYCLES=0`, `pready_o` is high in the first ACCESS cycle.
- **Aborted access.** If `psel_i` drops during ACCESS before completion, the FSM returns to IDLE, `wcnt` is cleared, and no register or counter update occurs.
- **Back-to-back transfers.** Consecutive SETUP/ACCESS pairs with no idle cycle are supported. `wcnt` restarts from 0 for each transfer.
- **Outputs are don't-touch outside completion.** `prdata_o` and `pslverr_o` are 0 whenever `pready_o=0`.

## Timing
- **Reset.** Rising edge with `rst_i=1` gives:
  - all `regs=0`, `regs_o=0`;
  - counter = 0, `wcnt=0`, FSM in IDLE.
  - Combinational outputs `pready_o`, `prdata_o`, `pslverr_o` are 0 while `rst_i=1`, regardless of the bus inputs.
- **Reset mid-transfer.** Reset asserted during ACCESS aborts the transfer: no commit, FSM in IDLE. The master must restart from SETUP.
- **Transfer latency.** SETUP = 1 cycle, then ACCESS = `WAIT_CYCLES+1` cycles. Total per transfer = `WAIT_CYCLES+2` cycles.
- **Write visibility.** Write data appears on `regs_o` the cycle after the completion edge. A read of the same register in the next transfer returns the new value.
- **Simultaneous reset and completion.** Reset wins: no write, no counter increment.

## Test plan
- **Reset, then reads.** Read `0xFFC` -> `prdata_o=0xA5B00001`, `pslverr_o=0`. Then read `0xFF8` -> `0x00000001`, i.e. the count from the first read only.
- **RW write/read with wait states** (`WAIT_CYCLES=2`). Write `0x004 <= 0xDEADBEEF`: `pready_o` is high exactly on the 3rd ACCESS cycle, and `regs_o[63:32]=0xDEADBEEF` on the next cycle. Readback returns `0xDEADBEEF`.
- **Error accesses.**
  - Write `0x002` (misaligned) -> `pslverr_o=1`, `regs_o` unchanged.
  - Read `0x020` with `NUM_REGS=8` -> `pslverr_o=1`, `prdata_o=0`.
  - Write `0xFFC` -> `pslverr_o=1`, ID still reads `0xA5B00001`.
- **Aborted transfer.** Drop `psel_i` after 1 ACCESS cycle of a write with `WAIT_CYCLES=3` -> no register change and no counter increment.
- **Back-to-back.** 4 writes to regs 0..3 (`WAIT_CYCLES=0`) with no idle cycles -> each completes in 2 cycles; all values land; counter reads 4 on the following read.
- **Reset during ACCESS.** Assert `rst_i` during the ACCESS of a write to reg 1 -> after reset, reg 1 = 0 and counter = 0; a subsequent transfer behaves normally.

Source files
------------

// File: rtl/apb_regbank_slave.sv
// APB3 register-bank slave: NUM_REGS read/write registers, a read-only
// access counter at 0xFF8 and a read-only ID register at 0xFFC.
// Every ACCESS phase is stretched by WAIT_CYCLES wait states.
// Illegal accesses complete with pslverr_o.
//
// Handshake: a transfer is in its ACCESS phase while psel_i & penable_i
// is high. It completes in the cycle where pready_o is high. All state
// side effects are committed on the rising edge that ends that cycle.
// prdata_o and pslverr_o carry meaning only in that cycle and are 0
// otherwise.
module apb_regbank_slave #(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [11:0]              paddr_i,
  input  logic                     psel_i,
  input  logic                     penable_i,
  input  logic                     pwrite_i,
  input  logic [31:0]              pwdata_i,
  output logic [31:0]              prdata_o,
  output logic                     pready_o,
  output logic                     pslverr_o,
  output logic [32*NUM_REGS-1:0]   regs_o
);

  localparam logic [10:0] NUM_REGS_W = 11'(NUM_REGS);
  localparam logic [3:0]  WAIT_W     = 4'(WAIT_CYCLES);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t      state;
  logic [3:0]  wcnt;
  logic [31:0] cnt;
  logic [31:0] regs [NUM_REGS];

  logic        bus_act;
  logic [9:0]  idx;
  logic        rw_hit;
  logic        cnt_hit;
  logic        id_hit;
  logic        bad_acc;
  logic [31:0] rd_rw;
  logic [31:0] rd_mux;

  assign bus_act = psel_i & penable_i;
  assign idx     = paddr_i[11:2];

  // Address decode. The CNT and ID offsets lie above any legal RW index,
  // so the three hit signals are mutually exclusive.
  assign rw_hit  = (paddr_i[1:0] == 2'b00) && ({1'b0, idx} < NUM_REGS_W);
  assign cnt_hit = (paddr_i == 12'hFF8);
  assign id_hit  = (paddr_i == 12'hFFC);
  assign bad_acc = ~(rw_hit | cnt_hit | id_hit) | (pwrite_i & (cnt_hit | id_hit));

  // The completion cycle. Reset forces it low, so nothing commits on a
  // reset edge.
  assign pready_o  = bus_act & (wcnt == WAIT_W) & ~rst_i;
  assign pslverr_o = pready_o & bad_acc;
  assign prdata_o  = (pready_o & ~pwrite_i & ~bad_acc) ? rd_mux : 32'h0;

  // Select the RW register addressed by idx.
  always_comb begin
    rd_rw = 32'h0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == 10'(i)) rd_rw = regs[i];
    end
  end

  // Read data source select. The counter is sampled before this transfer's
  // own increment.
  always_comb begin
    rd_mux = 32'h0;
    if (rw_hit)       rd_mux = rd_rw;
    else if (cnt_hit) rd_mux = cnt;
    else if (id_hit)  rd_mux = ID_VALUE;
  end

  // Access FSM with wait-state counter. wcnt stays 0 outside ACCESS.
  // A dropped psel_i/penable_i returns to IDLE without any commit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      wcnt  <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          wcnt <= 4'd0;
          if (bus_act && !pready_o) begin
            state <= ST_ACCESS;
            wcnt  <= 4'd1;
          end
        end
        ST_ACCESS: begin
          if (!bus_act || pready_o) begin
            state <= ST_IDLE;
            wcnt  <= 4'd0;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          wcnt  <= 4'd0;
        end
      endcase
    end
  end

  // Access counter: one count per completed transfer, good or errored.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt <= 32'h0;
    else if (pready_o) cnt <= cnt + 32'h1;
  end

  // RW register writes on a successful completed write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'h0;
    end else if (pready_o && pwrite_i && rw_hit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (idx == 10'(i)) regs[i] <= pwdata_i;
      end
    end
  end

  // Flat export of the register bank.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[32*g +: 32] = regs[g];
  end

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Directed bench for apb_regbank_slave. Three instances with 2, 0 and 3
// wait states share one APB bus. Each instance's psel is gated by the
// selector sel, so only the selected instance sees traffic.
module tb_apb_regbank_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  int          sel;

  logic        psel_v  [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];
  logic [255:0] regs_v [3];

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 3; k++) psel_v[k] = psel & (sel == k);
  end

  apb_regbank_slave #(.NUM_REGS(8), .WAIT_CYCLES(2)) u_w2 (
    .clk_i(clk), .rst_i(rst), .paddr_i(paddr), .psel_i(psel_v[0]),
    .penable_i(penable), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .prdata_o(prdata[0]), .pready_o(pready[0]), .pslverr_o(pslverr[0]),
    .regs_o(regs_v[0]));

  apb_regbank_slave #(.NUM_REGS(8), .WAIT_CYCLES(0)) u_w0 (
    .clk_i(clk), .rst_i(rst), .paddr_i(paddr), .psel_i(psel_v[1]),
    .penable_i(penable), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .prdata_o(prdata[1]), .pready_o(pready[1]), .pslverr_o(pslverr[1]),
    .regs_o(regs_v[1]));

  apb_regbank_slave #(.NUM_REGS(8), .WAIT_CYCLES(3)) u_w3 (
    .clk_i(clk), .rst_i(rst), .paddr_i(paddr), .psel_i(psel_v[2]),
    .penable_i(penable), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .prdata_o(prdata[2]), .pready_o(pready[2]), .pslverr_o(pslverr[2]),
    .regs_o(regs_v[2]));

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic int acc_cycles(input int s);
    case (s)
      0:       return 3;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // One SETUP cycle, then ACCESS until pready. Returns at the negedge of
  // the completion cycle with psel still high, so a following call gives
  // a back-to-back transfer.
  task automatic apb_xfer(input int s, input logic wr, input logic [11:0] a,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic er, output int n);
    logic done;
    @(posedge clk); #1;
    sel = s; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0; rd = 32'h0; er = 1'b0; done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (pready[s]) begin
        rd = prdata[s]; er = pslverr[s]; done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("xfer_done", {31'b0, done}, 32'h1);
  endtask

  task automatic rd_chk(input string tag, input int s, input logic [11:0] a,
                        input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] rd; logic er; int n;
    apb_xfer(s, 1'b0, a, 32'h0, rd, er, n);
    check({tag, "_data"}, rd, exp_d);
    check({tag, "_err"}, {31'b0, er}, {31'b0, exp_e});
    check({tag, "_cyc"}, n, acc_cycles(s));
  endtask

  task automatic wr_chk(input string tag, input int s, input logic [11:0] a,
                        input logic [31:0] wd, input logic exp_e);
    logic [31:0] rd; logic er; int n;
    apb_xfer(s, 1'b1, a, wd, rd, er, n);
    check({tag, "_err"}, {31'b0, er}, {31'b0, exp_e});
    check({tag, "_cyc"}, n, acc_cycles(s));
  endtask

  task automatic bus_idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 12'h0; pwdata = 32'h0; sel = 1;
    repeat (2) @(posedge clk);
    #1;
    // Reset with an active read on the zero-wait instance: outputs stay 0.
    psel = 1'b1; penable = 1'b1; paddr = 12'hFFC;
    @(negedge clk);
    check("rst_pready", {31'b0, pready[1]}, 32'h0);
    check("rst_prdata", prdata[1], 32'h0);
    check("rst_pslverr", {31'b0, pslverr[1]}, 32'h0);
    check("rst_regs", {31'b0, |regs_v[0]}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;

    // ID then counter, WAIT_CYCLES=2.
    rd_chk("id_rd", 0, 12'hFFC, 32'hA5B0_0001, 1'b0);
    rd_chk("cnt_rd1", 0, 12'hFF8, 32'h0000_0001, 1'b0);
    bus_idle();

    // RW write/readback with wait states.
    wr_chk("wr_r1", 0, 12'h004, 32'hDEAD_BEEF, 1'b0);
    bus_idle();
    @(negedge clk);
    check("regs_o_r1", regs_v[0][63:32], 32'hDEAD_BEEF);
    rd_chk("rd_r1", 0, 12'h004, 32'hDEAD_BEEF, 1'b0);
    bus_idle();

    // Error accesses.
    wr_chk("wr_misal", 0, 12'h002, 32'h1234_5678, 1'b1);
    bus_idle();
    @(negedge clk);
    check("misal_r0", regs_v[0][31:0], 32'h0);
    check("misal_r1", regs_v[0][63:32], 32'hDEAD_BEEF);
    rd_chk("rd_hole20", 0, 12'h020, 32'h0, 1'b1);
    wr_chk("wr_id", 0, 12'hFFC, 32'h0BAD_0BAD, 1'b1);
    rd_chk("id_rd2", 0, 12'hFFC, 32'hA5B0_0001, 1'b0);
    rd_chk("rd_misal5", 0, 12'h005, 32'h0, 1'b1);
    rd_chk("rd_holeff4", 0, 12'hFF4, 32'h0, 1'b1);
    rd_chk("cnt_rd2", 0, 12'hFF8, 32'd10, 1'b0);
    bus_idle();

    // Aborted write on the 3-wait instance.
    @(posedge clk); #1;
    sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("abort_pready", {31'b0, pready[2]}, 32'h0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("abort_regs_o", regs_v[2][95:64], 32'h0);
    rd_chk("abort_rd_r2", 2, 12'h008, 32'h0, 1'b0);
    rd_chk("abort_cnt", 2, 12'hFF8, 32'h1, 1'b0);
    bus_idle();

    // Back-to-back writes on the zero-wait instance, then the counter.
    for (int i = 0; i < 4; i++) begin
      wr_chk($sformatf("b2b_wr%0d", i), 1, 12'(4 * i), 32'hA000_0000 + 32'(i), 1'b0);
    end
    rd_chk("b2b_cnt", 1, 12'hFF8, 32'd4, 1'b0);
    bus_idle();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b_regs_o%0d", i), regs_v[1][32*i +: 32], 32'hA000_0000 + 32'(i));
    end
    for (int i = 0; i < 4; i++) begin
      rd_chk($sformatf("b2b_rd%0d", i), 1, 12'(4 * i), 32'hA000_0000 + 32'(i), 1'b0);
    end
    bus_idle();

    // Reset coinciding with the completion cycle of a write to reg 1.
    @(posedge clk); #1;
    sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    penable = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("rstacc_pready", {31'b0, pready[1]}, 32'h0);
    check("rstacc_pslverr", {31'b0, pslverr[1]}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    check("rstacc_r1", regs_v[1][63:32], 32'h0);
    check("rstacc_r0", regs_v[1][31:0], 32'h0);
    check("rstacc_w2_r1", regs_v[0][63:32], 32'h0);
    rd_chk("rstacc_cnt0", 1, 12'hFF8, 32'h0, 1'b0);
    wr_chk("rstacc_wr", 1, 12'h004, 32'h600D_F00D, 1'b0);
    rd_chk("rstacc_rd", 1, 12'h004, 32'h600D_F00D, 1'b0);
    rd_chk("rstacc_cnt3", 1, 12'hFF8, 32'd3, 1'b0);
    bus_idle();

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
